cic_compensator_mc: RTL and testbench

- Multi-channel, time-interleaved successor to the single-channel CIC droop compensator.
- Sits directly after a CIC decimator whose output carries a channel tag.
- Applies the 3-tap sparse FIR y[n] = x[n] − G·x[n−D] + x[n−2D] independently per channel, each channel with its own delay history.
- Adds in_ready backpressure, a synchronous history clear and a configurable centre gain.

---
 rtl/cic_compensator_pkg.sv | 23 ++
 rtl/cic_compensator_history.sv | 58 +++++
 rtl/cic_compensator_mc.sv | 80 ++++++++
 tb/tb_cic_compensator_mc.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_compensator_pkg.sv
// Shared sizing and arithmetic helpers for the multi-channel CIC droop compensator.
package cic_compensator_pkg;

   function automatic int full_width(input int in_bits, input int gain);
      return in_bits + $clog2(gain + 2);
   endfunction

   function automatic int chan_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Fit a full-precision value into 'bits' bits: clamp when sat is set, else two's-complement wrap.
   function automatic logic signed [63:0] resize(input logic signed [63:0] v, input int bits,
                                                 input bit sat);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (sat && v > hi) return hi;
      if (sat && v < lo) return lo;
      return (v <<< (64 - bits)) >>> (64 - bits);
   endfunction

endpackage

// File: rtl/cic_compensator_history.sv
// Per-channel 2D-deep sample history; exposes taps D-1 and 2D-1 of the addressed channel.
module cic_compensator_history
   import cic_compensator_pkg::*;
#(
   parameter int SampleBits  = 12,
   parameter int TapSpacing  = 3,
   parameter int NumChannels = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   clear,
   input  logic                                   we,
   input  logic [chan_width(NumChannels)-1:0]     channel,
   input  logic [SampleBits-1:0]                  sample,
   output logic [SampleBits-1:0]                  tap_d,
   output logic [SampleBits-1:0]                  tap_2d
);
   localparam int Depth = 2 * TapSpacing;

   logic [NumChannels-1:0][SampleBits-1:0] tap_d_all, tap_2d_all;

   for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      logic [Depth-1:0][SampleBits-1:0] h;
      logic                             sel;

      assign sel = we && (int'(channel) == c);

      // A clear coinciding with a write leaves the new sample as the only entry.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            h <= '0;
         end else if (clear) begin
            h <= '0;
            if (sel) h[0] <= sample;
         end else if (sel) begin
            h <= {h[Depth-2:0], sample};
         end
      end

      assign tap_d_all[c]  = h[TapSpacing-1];
      assign tap_2d_all[c] = h[Depth-1];
   end

   // Taps read as zero during clear so a same-cycle sample is filtered against empty history.
   always_comb begin
      tap_d  = '0;
      tap_2d = '0;
      if (!clear) begin
         for (int c = 0; c < NumChannels; c++) begin
            if (int'(channel) == c) begin
               tap_d  = tap_d_all[c];
               tap_2d = tap_2d_all[c];
            end
         end
      end
   end

endmodule

// File: rtl/cic_compensator_mc.sv
// Time-interleaved 3-tap CIC droop compensator: y = x[n] - G*x[n-D] + x[n-2D] per channel.
// Define CIC_COMPENSATOR_MC_SATURATE_EN to clamp instead of wrap when the output is narrower.
module cic_compensator_mc
   import cic_compensator_pkg::*;
#(
   parameter int InputLengthBits  = 12,
   parameter int OutputLengthBits = 19,
   parameter int FilterOrder      = 3,
   parameter int CenterGain       = 10,
   parameter int NumChannels      = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                clear,
   input  logic [InputLengthBits-1:0]          in,
   input  logic [chan_width(NumChannels)-1:0]  in_channel,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [OutputLengthBits-1:0]         out,
   output logic [chan_width(NumChannels)-1:0]  out_channel,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                channel_error
);
   localparam int W = full_width(InputLengthBits, CenterGain);
   localparam logic signed [W-1:0] Gain = W'(CenterGain);
`ifdef CIC_COMPENSATOR_MC_SATURATE_EN
   localparam bit Saturate = 1'b1;
`else
   localparam bit Saturate = 1'b0;
`endif

   logic                               accept, ch_ok, hist_we;
   logic signed [InputLengthBits-1:0]  tap_d, tap_2d;
   logic signed [W-1:0]                sum;
   logic [OutputLengthBits-1:0]        out_next;

   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign ch_ok    = int'(in_channel) < NumChannels;
   assign hist_we  = accept && ch_ok;

   cic_compensator_history #(
      .SampleBits  (InputLengthBits),
      .TapSpacing  (FilterOrder),
      .NumChannels (NumChannels)
   ) u_hist (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .we      (hist_we),
      .channel (in_channel),
      .sample  (in),
      .tap_d   (tap_d),
      .tap_2d  (tap_2d)
   );

   // W bits hold (G+2) full-scale inputs, so the sum itself never overflows.
   assign sum      = W'($signed(in)) - Gain * W'(tap_d) + W'(tap_2d);
   assign out_next = OutputLengthBits'(resize(64'(sum), OutputLengthBits, Saturate));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out           <= '0;
         out_channel   <= '0;
         out_valid     <= 1'b0;
         channel_error <= 1'b0;
      end else begin
         channel_error <= accept && !ch_ok;
         if (hist_we) begin
            out         <= out_next;
            out_channel <= in_channel;
            out_valid   <= 1'b1;
         end else if (out_ready) begin
            out_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cic_compensator_mc.sv
// Directed bench for cic_compensator_mc: default instance plus a 5-channel, 15-bit-output instance.
module tb_cic_compensator_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // default instance
   logic        clear = 0, in_valid = 0, out_ready = 0;
   logic [11:0] in_s = '0;
   logic [1:0]  in_ch = '0;
   logic        in_ready, out_valid, channel_error;
   logic [18:0] out;
   logic [1:0]  out_ch;

   // NumChannels=5, OutputLengthBits=15 instance
   logic        n_clear = 0, n_in_valid = 0, n_out_ready = 0;
   logic [11:0] n_in = '0;
   logic [2:0]  n_in_ch = '0;
   logic        n_in_ready, n_out_valid, n_channel_error;
   logic [14:0] n_out;
   logic [2:0]  n_out_ch;

   cic_compensator_mc dut (
      .clk(clk), .rst(rst), .clear(clear), .in(in_s), .in_channel(in_ch), .in_valid(in_valid),
      .in_ready(in_ready), .out(out), .out_channel(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .channel_error(channel_error)
   );

   cic_compensator_mc #(.OutputLengthBits(15), .NumChannels(5)) dut_n (
      .clk(clk), .rst(rst), .clear(n_clear), .in(n_in), .in_channel(n_in_ch),
      .in_valid(n_in_valid), .in_ready(n_in_ready), .out(n_out), .out_channel(n_out_ch),
      .out_valid(n_out_valid), .out_ready(n_out_ready), .channel_error(n_channel_error)
   );

`ifdef CIC_COMPENSATOR_MC_SATURATE_EN
   localparam int NarrowCenter = 16383;
`else
   localparam int NarrowCenter = -12288;
`endif

   task automatic send0(input int ch, input int x);
      in_valid = 1; in_ch = 2'(ch); in_s = 12'(x);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic send1(input int ch, input int x);
      n_in_valid = 1; n_in_ch = 3'(ch); n_in = 12'(x);
      @(posedge clk); #1;
      n_in_valid = 0;
   endtask

   task automatic test_reset;
      in_valid = 1; in_s = 12'd100; out_ready = 1;
      n_in_valid = 1; n_in = 12'd100; n_out_ready = 1;
      #12;
      n_vec++;
      if ({out, out_ch, out_valid, channel_error, in_ready} !== '0) begin
         n_err++;
         $display("FAIL reset_dut out=%0d ch=%0d v=%b err=%b rdy=%b want all 0",
                  $signed(out), out_ch, out_valid, channel_error, in_ready);
      end
      n_vec++;
      if ({n_out, n_out_ch, n_out_valid, n_channel_error, n_in_ready} !== '0) begin
         n_err++;
         $display("FAIL reset_dut_n out=%0d ch=%0d v=%b err=%b rdy=%b want all 0",
                  $signed(n_out), n_out_ch, n_out_valid, n_channel_error, n_in_ready);
      end
      in_valid = 0; n_in_valid = 0;
      @(posedge clk); #1;
      rst = 0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++; $display("FAIL reset_release in_ready=%b want 1", in_ready);
      end
   endtask

   task automatic test_impulse;
      int e[10];
      e = '{2047, 0, 0, -20470, 0, 0, 2047, 0, 0, 0};
      out_ready = 1;
      for (int k = 0; k < 10; k++) begin
         send0(0, (k == 0) ? 2047 : 0);
         n_vec++;
         if (out_valid !== 1'b1 || out !== 19'(e[k]) || out_ch !== 2'd0) begin
            n_err++;
            $display("FAIL impulse[%0d] out=%0d ch=%0d v=%b want %0d ch0 v1",
                     k, $signed(out), out_ch, out_valid, e[k]);
         end
      end
   endtask

   task automatic test_step;
      int e;
      for (int k = 0; k < 12; k++) begin
         send0(0, 2047);
         e = (k < 3) ? 2047 : (k < 6) ? -18423 : -16376;
         n_vec++;
         if (out_valid !== 1'b1 || out !== 19'(e)) begin
            n_err++;
            $display("FAIL step[%0d] out=%0d v=%b want %0d", k, $signed(out), out_valid, e);
         end
      end
   endtask

   task automatic test_clear;
      int e[4];
      e = '{5, 0, 0, -50};
      // history is full of 2047 from the step test
      for (int k = 0; k < 4; k++) begin
         clear = (k == 0);
         send0(0, (k == 0) ? 5 : 0);
         clear = 0;
         n_vec++;
         if (out !== 19'(e[k])) begin
            n_err++; $display("FAIL clear_accept[%0d] out=%0d want %0d", k, $signed(out), e[k]);
         end
      end
      out_ready = 0; clear = 1;
      @(posedge clk); #1;
      clear = 0;
      n_vec++;
      if (out_valid !== 1'b1 || out !== 19'(-50)) begin
         n_err++; $display("FAIL clear_holds_out out=%0d v=%b want -50 v1", $signed(out), out_valid);
      end
      out_ready = 1;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0 || out !== 19'(-50)) begin
         n_err++; $display("FAIL drain_hold out=%0d v=%b want -50 v0", $signed(out), out_valid);
      end
      for (int k = 0; k < 3; k++) begin
         send0(0, 0);
         n_vec++;
         if (out !== 19'd0) begin
            n_err++; $display("FAIL clear_history[%0d] out=%0d want 0", k, $signed(out));
         end
      end
   endtask

   task automatic test_back_to_back;
      int e[10];
      e = '{2047, 0, 0, -20470, 0, 0, 2047, 0, 0, 0};
      for (int r = 0; r < 10; r++) begin
         for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (in_ready !== 1'b1) begin
               n_err++; $display("FAIL b2b_ready r%0d c%0d in_ready=%b want 1", r, c, in_ready);
            end
            send0(c, (c == 0 && r == 0) ? 2047 : 0);
            n_vec++;
            if (out_valid !== 1'b1 || out_ch !== 2'(c) || out !== 19'((c == 0) ? e[r] : 0)) begin
               n_err++;
               $display("FAIL b2b r%0d c%0d out=%0d ch=%0d v=%b want %0d", r, c, $signed(out),
                        out_ch, out_valid, (c == 0) ? e[r] : 0);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int e[7];
      e = '{0, 0, -20470, 0, 0, 2047, 0};
      @(posedge clk); #1;
      out_ready = 0;
      in_valid = 1; in_ch = 2'd0; in_s = 12'd2047;
      @(posedge clk); #1;
      in_s = 12'd0;
      n_vec++;
      if (out_valid !== 1'b1 || out !== 19'd2047) begin
         n_err++; $display("FAIL bp_first out=%0d v=%b want 2047 v1", $signed(out), out_valid);
      end
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if ({in_ready, out_valid, out, out_ch} !== {1'b0, 1'b1, 19'd2047, 2'd0}) begin
            n_err++;
            $display("FAIL bp_stall[%0d] rdy=%b v=%b out=%0d ch=%0d want rdy0 v1 2047 ch0",
                     i, in_ready, out_valid, $signed(out), out_ch);
         end
      end
      out_ready = 1;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b1 || out !== 19'(e[k])) begin
            n_err++; $display("FAIL bp_resume[%0d] out=%0d v=%b want %0d", k, $signed(out), out_valid, e[k]);
         end
      end
      in_valid = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_channel_error;
      int e[3];
      e = '{0, 0, NarrowCenter};
      n_out_ready = 1;
      send1(0, -2048);
      n_vec++;
      if (n_out !== 15'(-2048) || n_out_valid !== 1'b1) begin
         n_err++; $display("FAIL narrow_first out=%0d v=%b want -2048", $signed(n_out), n_out_valid);
      end
      send1(5, 777);
      n_vec++;
      if (n_channel_error !== 1'b1 || n_out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL chan_err err=%b v=%b want err1 v0", n_channel_error, n_out_valid);
      end
      for (int k = 0; k < 3; k++) begin
         send1(0, 0);
         n_vec++;
         if (n_channel_error !== 1'b0 || n_out_valid !== 1'b1 || n_out !== 15'(e[k])) begin
            n_err++;
            $display("FAIL narrow_seq[%0d] out=%0d err=%b v=%b want %0d",
                     k, $signed(n_out), n_channel_error, n_out_valid, e[k]);
         end
      end
   endtask

   task automatic test_reset_midstream;
      #2 rst = 1;
      #1;
      n_vec++;
      if ({n_out, n_out_ch, n_out_valid, n_in_ready, out, out_valid} !== '0) begin
         n_err++;
         $display("FAIL mid_reset n_out=%0d n_v=%b n_rdy=%b out=%0d v=%b want all 0",
                  $signed(n_out), n_out_valid, n_in_ready, $signed(out), out_valid);
      end
      @(posedge clk); #1;
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         send1(0, 0);
         n_vec++;
         if (n_out !== 15'd0 || n_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset[%0d] out=%0d v=%b want 0", k, $signed(n_out), n_out_valid);
         end
      end
   endtask

   initial begin
      test_reset;
      test_impulse;
      test_step;
      test_clear;
      test_back_to_back;
      test_backpressure;
      test_channel_error;
      test_reset_midstream;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
